// File: rtl/alu_op_issuer.sv
// Initiator of the ALU request/response interface: debounced key press captures an op from
// the switches, issues it over valid/ready and shows the response. Optional: ALU_OP_ISSUER_ACCUM_EN.
module alu_op_issuer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] io_sw,
    input  logic       io_key,
    output logic       io_req_valid,
    input  logic       io_req_ready,
    output logic [1:0] io_req_fn,
    output logic [3:0] io_req_a,
    output logic [3:0] io_req_b,
    input  logic       io_resp_valid,
    input  logic [3:0] io_resp_result,
    output logic [9:0] io_led
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_SHOW  = 2'd3
    } state_t;

    logic            key_meta;
    logic            key_sync;
    logic            key_db;
    logic            key_db_q;
    logic [DB_W-1:0] db_cnt;
    logic            press;

    state_t          state;
    logic [1:0]      fn_q;
    logic [3:0]      a_q;
    logic [3:0]      b_q;
    logic [3:0]      result_q;
    logic            error_q;
    logic            busy_q;
    logic [TO_W-1:0] to_cnt;
    logic [3:0]      cap_a;

    // Synchronizer plus debounce: the level only flips after DEBOUNCE_CYCLES stable disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_meta <= 1'b0;
            key_sync <= 1'b0;
            key_db   <= 1'b0;
            key_db_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            key_meta <= io_key;
            key_sync <= key_meta;
            key_db_q <= key_db;
            if (key_sync == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                key_db <= ~key_db;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign press = key_db & ~key_db_q;

`ifdef ALU_OP_ISSUER_ACCUM_EN
    // The accumulator is the shown result; the switch operand a is not used in this mode.
    logic unused_sw_a;
    assign unused_sw_a = ^io_sw[5:2];
    assign cap_a       = result_q;
`else
    assign cap_a = io_sw[5:2];
`endif

    // Request handshake: a transfer happens on a clock edge where io_req_valid && io_req_ready;
    // fn/a/b are held while io_req_valid is high. io_resp_valid is a one-cycle strobe, honoured in WAIT only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            io_req_valid <= 1'b0;
            fn_q         <= 2'd0;
            a_q          <= 4'd0;
            b_q          <= 4'd0;
            result_q     <= 4'd0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            to_cnt       <= '0;
        end else begin
            case (state)
                S_IDLE, S_SHOW: begin
                    if (press) begin
                        fn_q         <= io_sw[1:0];
                        a_q          <= cap_a;
                        b_q          <= io_sw[9:6];
                        error_q      <= 1'b0;
                        io_req_valid <= 1'b1;
                        busy_q       <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (io_req_ready) begin
                        io_req_valid <= 1'b0;
                        to_cnt       <= '0;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response on the expiry cycle takes priority over the timeout.
                    if (io_resp_valid) begin
                        result_q <= io_resp_result;
                        busy_q   <= 1'b0;
                        state    <= S_SHOW;
                    end else if (to_cnt == TO_LAST) begin
                        result_q <= 4'd0;
                        error_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= S_SHOW;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_req_fn = fn_q;
    assign io_req_a  = a_q;
    assign io_req_b  = b_q;
    assign io_led    = {error_q, busy_q, 2'b00, fn_q, result_q};

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: directed key presses, a configurable responder, and a transaction-level
// model of the shown result/error/fn checked on every cycle.
module tb_alu_op_issuer;

    localparam int DEB = 4;
    localparam int TMO = 16;
`ifdef ALU_OP_ISSUER_ACCUM_EN
    localparam bit ACCUM = 1'b1;
`else
    localparam bit ACCUM = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [9:0] io_sw;
    logic       io_key;
    logic       io_req_valid;
    logic       io_req_ready;
    logic [1:0] io_req_fn;
    logic [3:0] io_req_a;
    logic [3:0] io_req_b;
    logic       io_resp_valid;
    logic [3:0] io_resp_result;
    logic [9:0] io_led;

    alu_op_issuer #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .io_sw         (io_sw),
        .io_key        (io_key),
        .io_req_valid  (io_req_valid),
        .io_req_ready  (io_req_ready),
        .io_req_fn     (io_req_fn),
        .io_req_a      (io_req_a),
        .io_req_b      (io_req_b),
        .io_resp_valid (io_resp_valid),
        .io_resp_result(io_resp_result),
        .io_led        (io_led)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- shared state ----------------
    int checks = 0;
    int errors = 0;
    int n_req  = 0;
    int stall_cfg  = 0;
    bit resp_en    = 1'b1;
    int resp_delay = 1;
    bit inject_resp = 1'b0;
    logic [3:0] last_a = 4'd0;
    logic [9:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] alu(input logic [1:0] fn, input logic [3:0] a, input logic [3:0] b);
        case (fn)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // ---------------- ready driver (stalls each new request stall_cfg cycles) ----------------
    int  st_left = 0;
    bit  st_seen = 1'b0;
    initial begin
        io_req_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (io_req_valid && !st_seen) begin
                st_seen = 1'b1;
                st_left = stall_cfg;
            end
            if (!io_req_valid) st_seen = 1'b0;
            if (io_req_valid && st_left > 0) begin
                io_req_ready = 1'b0;
                st_left--;
            end else begin
                io_req_ready = 1'b1;
            end
        end
    end

    // ---------------- responder: answers resp_delay cycles after acceptance ----------------
    initial begin
        int         cd;
        bit         acc;
        logic [3:0] r;
        logic [3:0] r_next;
        cd = 0;
        r  = 4'd0;
        io_resp_valid  = 1'b0;
        io_resp_result = 4'd0;
        forever begin
            @(negedge clk);
            acc    = io_req_valid && io_req_ready && !reset;
            r_next = alu(io_req_fn, io_req_a, io_req_b);
            @(posedge clk);
            #2;
            if (acc && resp_en) begin
                cd = resp_delay;
                r  = r_next;
            end
            io_resp_valid = inject_resp;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    io_resp_valid  = 1'b1;
                    io_resp_result = r;
                end
            end
        end
    end

    // ---------------- model + per-cycle compare ----------------
    logic [1:0] m_fn;
    logic [3:0] m_res;
    logic       m_err;
    logic [3:0] p_res;
    logic       p_err;
    int         p_wait;
    bit         infl;
    bit         prev_busy;
    bit         prev_valid;
    logic [9:0] prev_req;
    int         wait_cnt;
    int         stall_cnt;

    always @(negedge clk) begin
        logic [9:0] sw;
        logic [3:0] ea;
        if (reset) begin
            exp_q.delete();
            m_fn = 2'd0; m_res = 4'd0; m_err = 1'b0;
            infl = 1'b0; prev_busy = 1'b0; prev_valid = 1'b0;
            prev_req = 10'd0; wait_cnt = 0; stall_cnt = 0;
        end else begin
            check("led_7_6_zero", io_led[7:6], 0);
            if (io_req_valid) check("busy_while_valid", io_led[8], 1);
            if (prev_valid && io_req_valid)
                check("req_stable", {io_req_b, io_req_a, io_req_fn}, prev_req);
            if (io_req_valid && !io_req_ready) stall_cnt++;
            if (io_led[8] && !io_req_valid) wait_cnt++;
            if (io_req_valid && io_req_ready) begin
                n_req++;
                if (exp_q.size() == 0) begin
                    check("extra_req", 1, 0);
                end else begin
                    sw = exp_q.pop_front();
                    ea = ACCUM ? m_res : sw[5:2];
                    check("req_fn", io_req_fn, sw[1:0]);
                    check("req_a", io_req_a, ea);
                    check("req_b", io_req_b, sw[9:6]);
                    check("stall_cycles", stall_cnt, stall_cfg);
                    last_a = io_req_a;
                    if (resp_en && resp_delay <= TMO) begin
                        p_res  = alu(sw[1:0], ea, sw[9:6]);
                        p_err  = 1'b0;
                        p_wait = resp_delay;
                    end else begin
                        p_res  = 4'd0;
                        p_err  = 1'b1;
                        p_wait = TMO;
                    end
                    m_fn = sw[1:0];
                    infl = 1'b1;
                end
                stall_cnt = 0;
                wait_cnt  = 0;
            end
            if (prev_busy && !io_led[8]) begin
                if (infl) begin
                    check("wait_cycles", wait_cnt, p_wait);
                    m_res = p_res;
                    m_err = p_err;
                    infl  = 1'b0;
                end else begin
                    check("done_without_request", 1, 0);
                end
                wait_cnt = 0;
            end
            if (!io_led[8]) check("led_idle", io_led, {m_err, 1'b0, 2'b00, m_fn, m_res});
            prev_busy  = io_led[8];
            prev_valid = io_req_valid;
            prev_req   = {io_req_b, io_req_a, io_req_fn};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_key(input int hold);
        io_key = 1'b1;
        tick(hold);
        io_key = 1'b0;
        tick(8);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!io_led[8] && !io_req_valid) begin
                tick(1);
                return;
            end
        end
        check("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_in_wait(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (io_led[8] && !io_req_valid) return;
        end
        check("wait_state_timeout", 1, 0);
    endtask

    task automatic issue(input logic [9:0] sw);
        io_sw = sw;
        exp_q.push_back(sw);
        press_key(10);
        wait_idle(80);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        reset  = 1'b1;
        io_sw  = 10'd0;
        io_key = 1'b0;
        tick(1);
        check("reset_led", io_led, 0);
        check("reset_valid", io_req_valid, 0);
        tick(2);
        reset = 1'b0;
        tick(2);

        // basic add: b=3 a=5 fn=0
        issue(10'b0011_0101_00);
        check("basic_led", io_led, ACCUM ? 10'b00_00_00_0011 : 10'b00_00_00_1000);
        check("basic_one_req", n_req, 1);

        // sub / or / and with various response latencies
        issue(10'b0101_0010_01);
        resp_delay = 3;
        issue(10'b1100_1010_10);
        issue(10'b1100_1010_11);
        resp_delay = 1;

        // back-pressure: ready low for 5 cycles
        stall_cfg = 5;
        issue(10'b0110_0111_00);
        stall_cfg = 0;

        // timeout, then recovery
        resp_en = 1'b0;
        issue(10'b0001_0001_00);
        check("timeout_err", io_led[9], 1);
        check("timeout_res", io_led[3:0], 0);
        resp_en = 1'b1;
        issue(10'b0010_0100_00);
        check("recover_err", io_led[9], 0);

        // response on the expiry cycle wins
        resp_delay = TMO;
        issue(10'b0001_0011_10);
        check("expiry_resp_err", io_led[9], 0);
        resp_delay = 1;

        // bounce: toggles every 2 cycles, then settles high
        base  = n_req;
        io_sw = 10'b0100_0001_00;
        exp_q.push_back(io_sw);
        for (int i = 0; i < 10; i++) begin
            io_key = (i % 2 == 0);
            tick(2);
        end
        press_key(10);
        wait_idle(80);
        check("bounce_one_req", n_req, base + 1);

        // second press during WAIT is dropped
        base       = n_req;
        resp_delay = TMO;
        io_sw      = 10'b0011_0011_00;
        exp_q.push_back(io_sw);
        io_key = 1'b1;
        wait_in_wait(40);
        io_key = 1'b0;
        tick(5);
        io_key = 1'b1;
        tick(10);
        io_key = 1'b0;
        tick(8);
        wait_idle(80);
        tick(10);
        check("drop_one_req", n_req, base + 1);
        resp_delay = 1;

        // async reset during WAIT, away from the clock edge
        base       = n_req;
        resp_delay = 12;
        io_sw      = 10'b0010_0010_00;
        exp_q.push_back(io_sw);
        io_key = 1'b1;
        wait_in_wait(40);
        tick(3);
        #2;
        reset  = 1'b1;
        io_key = 1'b0;
        #1;
        check("async_reset_led", io_led, 0);
        check("async_reset_valid", io_req_valid, 0);
        tick(2);
        reset = 1'b0;
        tick(2);
        inject_resp = 1'b1;
        tick(1);
        inject_resp = 1'b0;
        tick(14);
        check("late_resp_led", io_led, 0);
        check("late_resp_no_req", n_req, base + 1);
        resp_delay = 1;

`ifdef ALU_OP_ISSUER_ACCUM_EN
        // accumulator: fn=0, b=2, switch a ignored
        pulse_reset();
        issue(10'b0010_1111_00);
        check("accum_res1", io_led[3:0], 2);
        check("accum_a1", last_a, 0);
        issue(10'b0010_1111_00);
        check("accum_res2", io_led[3:0], 4);
        check("accum_a2", last_a, 2);
        issue(10'b0010_1111_00);
        check("accum_res3", io_led[3:0], 6);
        check("accum_a3", last_a, 4);
`endif

        tick(4);
        check("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Initiator side of the ALU request/response interface. Captures an operation from the board switches on a debounced key press, issues it to an ALU responder over a valid/ready request channel, waits for the response, and shows the result on the LEDs.
- Sits between board I/O (switches, key, LEDs) and a registered ALU wrapper. It replaces the direct switch-to-ALU wiring with a sequenced, handshaked path.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a new key level (5 ms at 50 MHz); benches override to 4.
- TIMEOUT_CYCLES, 16, maximum cycles to wait in WAIT for io_resp_valid; minimum value 1.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-high reset.
- io_sw  input  10  operation select: [1:0] fn, [5:2] a, [9:6] b.
- io_key  input  1  raw push button, active-high, asynchronous to clk.
- io_req_valid  output  1  request valid.
- io_req_ready  input  1  responder accepts request.
- io_req_fn  output  2  opcode: 0 add, 1 sub, 2 or, 3 and.
- io_req_a  output  4  operand a.
- io_req_b  output  4  operand b.
- io_resp_valid  input  1  single-cycle response strobe.
- io_resp_result  input  4  response data.
- io_led  output  10  [3:0] result, [5:4] last fn, [7:6] 0, [8] busy, [9] timeout error.

Behaviour:
- Reset (async, active-high) clears all of the following:
  - state = IDLE; io_req_valid = 0; fn/a/b registers = 0; result = 0; error = 0; io_led = 0.
  - Synchronizer flops = 0; debounced level = 0; debounce and timeout counters = 0.
- Reset asserted mid-transaction abandons the transaction. A request being presented is dropped with no further handshake.
- Key path:
  - 2-FF synchronizer on io_key.
  - Debounce counter resets whenever the synchronized level equals the debounced level. Otherwise it increments.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A press event is a one-cycle pulse on the 0->1 transition of the debounced level.
  - Key-to-press latency is 2 + DEBOUNCE_CYCLES cycles.
- FSM (4 states):
  - IDLE: on press, register fn=io_sw[1:0], a=io_sw[5:2], b=io_sw[9:6], clear error, go to ISSUE.
  - ISSUE: io_req_valid=1. fn/a/b stay stable and unchanged until accepted. When io_req_valid && io_req_ready is sampled at a clock edge, go to WAIT and clear the timeout counter. io_req_valid is deasserted from the next cycle.
  - WAIT: io_resp_valid is sampled only in this state.
    - io_resp_valid=1: capture io_resp_result, go to SHOW.
    - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without a response: result=0, error=1, go to SHOW.
    - If a response arrives in the same cycle as timeout expiry, the response wins and error stays 0.
  - SHOW: hold io_led. On press, capture new operands and go to ISSUE directly, as IDLE does.
- Press events in ISSUE or WAIT are dropped, not queued.
- io_resp_valid outside WAIT is ignored. A responder must therefore respond no earlier than one cycle after acceptance.
- busy (io_led[8]) = state is ISSUE or WAIT.
- io_led[5:4] = registered fn. It is updated at capture.
- Width rules: operands and result are 4-bit; no widening or sign handling in this block. io_led[7:6] is tied 0.

Optional Feature:
- Macro ALU_OP_ISSUER_ACCUM_EN.
- Defined (accumulator mode): at capture, operand a comes from the current result register instead of io_sw[5:2]. io_sw[5:2] is ignored. After reset the accumulator is 0; a timed-out transaction leaves it at 0.
- Not defined: a = io_sw[5:2], and no logic referencing the accumulator path is generated.

Test Plan:
- Basic add (DEBOUNCE_CYCLES=4), ready tied 1, 1-cycle responder:
  - Stimulus: sw = b 3, a 5, fn 0 (10'b0011_0101_00); key held high for 10 cycles.
  - Required: exactly one request with fn=0, a=5, b=3; response 8; io_led = 10'b00_00_00_1000.
- Back-pressure: io_req_ready low for 5 cycles during ISSUE.
  - Required: io_req_valid high and fn/a/b unchanged for all 5 cycles; one acceptance when ready rises; busy=1 throughout.
- Timeout (TIMEOUT_CYCLES=16): responder never responds.
  - Required: exactly 16 cycles in WAIT, then io_led[9]=1 and io_led[3:0]=0.
  - A following press with a working responder clears io_led[9].
- Bounce and dropped presses:
  - Key toggles every 2 cycles for 20 cycles, then settles high. Required: exactly one press.
  - A second press during WAIT. Required: no second request issued.
- Async reset: reset asserted during WAIT, away from any clk edge.
  - Required: io_led=0 and io_req_valid=0 immediately.
  - A late io_resp_valid after reset release has no effect.
- With ALU_OP_ISSUER_ACCUM_EN: press with fn=0, b=2 three times (sw[5:2]=15).
  - Required: results 2, 4, 6; io_req_a = 0, 2, 4.
